tl_ul_arbiter: RTL
==================

# tl_ul_arbiter

TileLink-UL N-to-1 arbiter that shares one slave port (e.g. the BIOS ROM or a downstream switch) between several masters, such as CPU instruction fetch, CPU load/store and a debug or DMA master. Grants are round-robin, and exactly one transaction is in flight at a time. The arbiter holds a grant from the A-channel request until the matching D-channel response completes. It sits between the masters and the slave in the SoC top level and is transparent to opcode, size, source, mask and data.

## Interface
- XLEN, 32, data/address width
- SID_WIDTH, 8, source ID width
- NUM_MASTERS, 2, number of requesters (≥2)
- GW, $clog2(NUM_MASTERS), grant index width (derived)

- clk  in  1  system clock; sole clock domain
- reset  in  1  asynchronous, active-high reset
- m_a_valid / m_a_ready  in / out  NUM_MASTERS  per-master A handshake
- m_a_opcode, m_a_param, m_a_size  in  NUM_MASTERS*3 each  packed, master i at [3i+2:3i]
- m_a_source  in  NUM_MASTERS*SID_WIDTH  packed
- m_a_address, m_a_data  in  NUM_MASTERS*XLEN each  packed
- m_a_mask  in  NUM_MASTERS*XLEN/8  packed
- m_d_valid / m_d_ready  out / in  NUM_MASTERS  per-master D handshake
- m_d_opcode 3, m_d_param 2, m_d_size 3, m_d_source SID_WIDTH, m_d_data XLEN, m_d_corrupt 1, m_d_denied 1  out  D payload broadcast to all masters
- s_a_valid / s_a_ready  out / in  1  slave A handshake
- s_a_opcode 3, s_a_param 3, s_a_size 3, s_a_source SID_WIDTH, s_a_address XLEN, s_a_mask XLEN/8, s_a_data XLEN  out  A payload
- s_d_valid / s_d_ready  in / out  1  slave D handshake
- s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_data, s_d_corrupt, s_d_denied  in  widths as m_d_*
- busy  out  1  state ≠ IDLE
- grant  out  GW  index of the currently or last granted master

## Operation
- FSM states:
  - IDLE
    - If any m_a_valid is high, select the first requester scanning from (last_grant+1) mod N upward with wrap.
    - Register it into grant and move to ADDR.
    - If no request, stay in IDLE.
  - ADDR
    - s_a_valid = m_a_valid[grant]; s_a_* payload = the granted master's slice.
    - m_a_ready[grant] = s_a_ready.
    - On s_a_valid & s_a_ready, move to RESP.
  - RESP
    - m_d_valid[grant] = s_d_valid; s_d_ready = m_d_ready[grant].
    - On s_d_valid & s_d_ready, set last_grant ← grant and return to IDLE.
- Signals are forced to 0 in every state other than the one that drives them:
  - m_a_ready, m_d_valid for non-granted masters
  - s_a_valid and s_a_* payload outside ADDR
  - s_d_ready outside RESP
- m_d_* payload is s_d_* passed through combinationally in all states; validity is gated by m_d_valid.
- Source IDs pass through unmodified; a single outstanding transaction makes source remapping unnecessary.
- A granted master that deasserts m_a_valid in ADDR (a TL protocol violation) does not release the grant. The arbiter waits in ADDR.
- s_d_valid outside RESP: the arbiter does not forward it and holds s_d_ready at 0, so the response stalls at the slave.
- Masters not granted see m_a_ready=0 and must hold their requests. No request is dropped.
- Requests arriving while busy are considered at the next IDLE. Round-robin guarantees each requester is served within N transactions.

## Timing
- Reset values: state IDLE, grant 0, last_grant NUM_MASTERS-1 (master 0 wins first), busy 0, all valid/ready outputs 0, s_a payload 0.
- Reset asserted mid-transaction:
  - Returns to IDLE immediately (asynchronously).
  - Any in-flight slave response is abandoned; the slave must also be reset.
- Request latency:
  - m_a_valid rising in cycle 0 produces grant registered at the cycle 0→1 edge.
  - s_a_valid is high in cycle 1.
  - The earliest A handshake is in cycle 1.
- Response: same-cycle combinational D pass-through; the earliest D handshake is the cycle after the A handshake.
- Turnaround: one IDLE cycle between consecutive transactions, so the minimum period is 3 cycles per transaction with a 1-cycle slave.
- No combinational path from m_a_valid to m_a_ready. All readies depend on state, grant and the opposite-side ready only.

## Test plan
- Single master: after reset, master 0 issues Get at 0x8000_0004.
  - Required: s_a_valid in cycle 1 with address 0x8000_0004 and source 0x05.
  - Slave returns AccessAckData 0xDEADBEEF. m_d_valid[0]=1 with data 0xDEADBEEF, m_d_valid[1]=0.
  - busy returns to 0 the cycle after the D handshake.
- Contention: masters 0 and 1 hold m_a_valid continuously.
  - Required grant order 0,1,0,1 over 4 transactions; no master is granted twice in a row.
- Backpressure:
  - s_a_ready low for 5 cycles: s_a payload is held stable and m_a_ready[grant]=0 throughout.
  - m_d_ready low for 4 cycles: s_d_ready=0 throughout and the D payload passes through unchanged.
- Stray response: s_d_valid pulsed while IDLE.
  - Required: no m_d_valid, s_d_ready=0, state stays IDLE.
- Reset mid-RESP: reset asserted with the A handshake done and D pending.
  - Required: busy=0 and all valids/readies 0 asynchronously.
  - After release, master 0 is granted first again.
- NUM_MASTERS=3, only master 2 requesting; last_grant=0.
  - Required: grant=2 within 1 cycle and the transaction completes; m_a_ready[0] and m_a_ready[1] stay 0.

Source files
------------

// File: rtl/tl_ul_arbiter.sv
// TileLink-UL N-to-1 round-robin arbiter with a single outstanding transaction.
// The grant is held from the A request until the matching D response completes.
//
// state | meaning
// IDLE  | no transaction; pick the next requester round-robin from last_grant+1
// ADDR  | A channel of the granted master connected to the slave
// RESP  | D channel of the slave connected to the granted master
module tl_ul_arbiter #(
    parameter int XLEN        = 32,
    parameter int SID_WIDTH   = 8,
    parameter int NUM_MASTERS = 2,
    parameter int GW          = $clog2(NUM_MASTERS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS-1:0]          m_a_valid,
    output logic [NUM_MASTERS-1:0]          m_a_ready,
    input  logic [NUM_MASTERS*3-1:0]        m_a_opcode,
    input  logic [NUM_MASTERS*3-1:0]        m_a_param,
    input  logic [NUM_MASTERS*3-1:0]        m_a_size,
    input  logic [NUM_MASTERS*SID_WIDTH-1:0] m_a_source,
    input  logic [NUM_MASTERS*XLEN-1:0]     m_a_address,
    input  logic [NUM_MASTERS*XLEN-1:0]     m_a_data,
    input  logic [NUM_MASTERS*XLEN/8-1:0]   m_a_mask,
    output logic [NUM_MASTERS-1:0]          m_d_valid,
    input  logic [NUM_MASTERS-1:0]          m_d_ready,
    output logic [2:0]                      m_d_opcode,
    output logic [1:0]                      m_d_param,
    output logic [2:0]                      m_d_size,
    output logic [SID_WIDTH-1:0]            m_d_source,
    output logic [XLEN-1:0]                 m_d_data,
    output logic                            m_d_corrupt,
    output logic                            m_d_denied,
    output logic                            s_a_valid,
    input  logic                            s_a_ready,
    output logic [2:0]                      s_a_opcode,
    output logic [2:0]                      s_a_param,
    output logic [2:0]                      s_a_size,
    output logic [SID_WIDTH-1:0]            s_a_source,
    output logic [XLEN-1:0]                 s_a_address,
    output logic [XLEN/8-1:0]               s_a_mask,
    output logic [XLEN-1:0]                 s_a_data,
    input  logic                            s_d_valid,
    output logic                            s_d_ready,
    input  logic [2:0]                      s_d_opcode,
    input  logic [1:0]                      s_d_param,
    input  logic [2:0]                      s_d_size,
    input  logic [SID_WIDTH-1:0]            s_d_source,
    input  logic [XLEN-1:0]                 s_d_data,
    input  logic                            s_d_corrupt,
    input  logic                            s_d_denied,
    output logic                            busy,
    output logic [GW-1:0]                   grant
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] last_grant, grant_nxt, last_grant_nxt;
    logic [GW-1:0] cand, pick;
    logic          found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Scan from last_grant+1 with wrap; the first hit wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = GW'((int'(last_grant) + i) % NUM_MASTERS);
            if (!found && m_a_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: if (found) begin
                state_nxt = ADDR;
                grant_nxt = pick;
            end
            ADDR: if (s_a_valid && s_a_ready) state_nxt = RESP;
            RESP: if (s_d_valid && s_d_ready) begin
                state_nxt      = IDLE;
                last_grant_nxt = grant;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Readies depend only on state, grant and the opposite-side ready.
    always_comb begin
        m_a_ready   = '0;
        m_d_valid   = '0;
        s_a_valid   = 1'b0;
        s_a_opcode  = '0;
        s_a_param   = '0;
        s_a_size    = '0;
        s_a_source  = '0;
        s_a_address = '0;
        s_a_mask    = '0;
        s_a_data    = '0;
        s_d_ready   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant == GW'(i)) begin
                if (state == ADDR) begin
                    s_a_valid    = m_a_valid[i];
                    m_a_ready[i] = s_a_ready;
                    s_a_opcode   = m_a_opcode[3*i +: 3];
                    s_a_param    = m_a_param[3*i +: 3];
                    s_a_size     = m_a_size[3*i +: 3];
                    s_a_source   = m_a_source[SID_WIDTH*i +: SID_WIDTH];
                    s_a_address  = m_a_address[XLEN*i +: XLEN];
                    s_a_mask     = m_a_mask[(XLEN/8)*i +: XLEN/8];
                    s_a_data     = m_a_data[XLEN*i +: XLEN];
                end
                if (state == RESP) begin
                    m_d_valid[i] = s_d_valid;
                    s_d_ready    = m_d_ready[i];
                end
            end
        end
    end

    assign m_d_opcode  = s_d_opcode;
    assign m_d_param   = s_d_param;
    assign m_d_size    = s_d_size;
    assign m_d_source  = s_d_source;
    assign m_d_data    = s_d_data;
    assign m_d_corrupt = s_d_corrupt;
    assign m_d_denied  = s_d_denied;
    assign busy        = (state != IDLE);

endmodule
